// File: rtl/exc_ctrl.sv
// Precise-exception controller for the MEM stage: prioritises exception flags,
// drives the CP0 exception request and sequences flush/redirect. Macro: EXC_TIMER_INT_EN.
module exc_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid_i,
    input  logic        stall_i,
    input  logic [31:0] pc_i,
    input  logic        is_in_delayslot_i,
    input  logic        if_adel_i,
    input  logic        id_ri_i,
    input  logic        id_sys_i,
    input  logic        id_bp_i,
    input  logic        id_eret_i,
    input  logic        ex_ov_i,
    input  logic        mem_adel_i,
    input  logic        mem_ades_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    input  logic        timer_int_i,
    output logic        except_en_o,
    output logic [31:0] except_type_o,
    output logic [31:0] except_pc_o,
    output logic        except_delayslot_o,
    output logic [31:0] badvaddr_o,
    output logic        flush_o,
    output logic        mem_kill_o,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o
);

    localparam logic [31:0] EXC_TYPE_INT  = 32'd1;
    localparam logic [31:0] EXC_TYPE_ADEL = 32'd4;
    localparam logic [31:0] EXC_TYPE_ADES = 32'd5;
    localparam logic [31:0] EXC_TYPE_SYS  = 32'd8;
    localparam logic [31:0] EXC_TYPE_BP   = 32'd9;
    localparam logic [31:0] EXC_TYPE_RI   = 32'd10;
    localparam logic [31:0] EXC_TYPE_OV   = 32'd12;
    localparam logic [31:0] EXC_TYPE_ERET = 32'd14;

    typedef enum logic {
        IDLE,
        FLUSH
    } state_t;

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic [7:0]  ip;
    logic        int_req;
    logic [31:0] exc_code;
    logic [31:0] target_pc;
    logic        take;
    logic        unused_bits;

`ifdef EXC_TIMER_INT_EN
    assign ip = {cause_i[15] | timer_int_i, cause_i[14:8]};
    assign unused_bits = ^{status_i[31:23], status_i[21:16], status_i[7:2],
                           cause_i[31:16], cause_i[7:0]};
`else
    assign ip = cause_i[15:8];
    assign unused_bits = ^{status_i[31:23], status_i[21:16], status_i[7:2],
                           cause_i[31:16], cause_i[7:0], timer_int_i};
`endif

    assign int_req = (|(ip & status_i[15:8])) & status_i[0] & ~status_i[1];

    // INT sits above every synchronous flag, so ERET with a pending interrupt reports INT.
    always_comb begin
        exc_code   = '0;
        badvaddr_o = mem_addr_i;
        if (int_req) begin
            exc_code = EXC_TYPE_INT;
        end else if (if_adel_i) begin
            exc_code   = EXC_TYPE_ADEL;
            badvaddr_o = pc_i;
        end else if (id_ri_i) begin
            exc_code = EXC_TYPE_RI;
        end else if (id_sys_i) begin
            exc_code = EXC_TYPE_SYS;
        end else if (id_bp_i) begin
            exc_code = EXC_TYPE_BP;
        end else if (id_eret_i) begin
            exc_code = EXC_TYPE_ERET;
        end else if (ex_ov_i) begin
            exc_code = EXC_TYPE_OV;
        end else if (mem_adel_i) begin
            exc_code = EXC_TYPE_ADEL;
        end else if (mem_ades_i) begin
            exc_code = EXC_TYPE_ADES;
        end
    end

    always_comb begin
        target_pc = 32'h8000_0380;
        if (exc_code == EXC_TYPE_ERET) begin
            target_pc = epc_i;
        end else if (status_i[22]) begin
            target_pc = 32'hBFC0_0380;
        end
    end

    assign take = inst_valid_i & ~stall_i & (state == IDLE) & (exc_code != '0);

    assign except_en_o        = take;
    assign except_type_o      = take ? exc_code : '0;
    assign mem_kill_o         = take;
    assign flush_o            = take | (state == FLUSH);
    assign except_pc_o        = pc_i;
    assign except_delayslot_o = is_in_delayslot_i;

    // The counter runs regardless of stall; FLUSH outlasts the CP0 EXL update.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (take) begin
                    state_next = FLUSH;
                    cnt_next   = 4'(FLUSH_CYCLES - 1);
                end
            end
            FLUSH: begin
                if (cnt == '0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            redirect_o    <= 1'b0;
            redirect_pc_o <= '0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            redirect_o <= take;
            if (take) begin
                redirect_pc_o <= target_pc;
            end
        end
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: stimulus queues expected exceptions/redirects and
// per-cycle control levels; a negedge monitor does every comparison.
module tb_exc_ctrl;

    localparam int unsigned FC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid_i, stall_i, is_in_delayslot_i;
    logic [31:0] pc_i, mem_addr_i, status_i, cause_i, epc_i;
    logic        if_adel_i, id_ri_i, id_sys_i, id_bp_i, id_eret_i, ex_ov_i;
    logic        mem_adel_i, mem_ades_i, timer_int_i;
    logic        except_en_o, except_delayslot_o, flush_o, mem_kill_o, redirect_o;
    logic [31:0] except_type_o, except_pc_o, badvaddr_o, redirect_pc_o;

    exc_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst(rst),
        .inst_valid_i(inst_valid_i), .stall_i(stall_i), .pc_i(pc_i),
        .is_in_delayslot_i(is_in_delayslot_i),
        .if_adel_i(if_adel_i), .id_ri_i(id_ri_i), .id_sys_i(id_sys_i), .id_bp_i(id_bp_i),
        .id_eret_i(id_eret_i), .ex_ov_i(ex_ov_i),
        .mem_adel_i(mem_adel_i), .mem_ades_i(mem_ades_i), .mem_addr_i(mem_addr_i),
        .status_i(status_i), .cause_i(cause_i), .epc_i(epc_i), .timer_int_i(timer_int_i),
        .except_en_o(except_en_o), .except_type_o(except_type_o), .except_pc_o(except_pc_o),
        .except_delayslot_o(except_delayslot_o), .badvaddr_o(badvaddr_o),
        .flush_o(flush_o), .mem_kill_o(mem_kill_o),
        .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] typ;
        logic [31:0] badv;
        logic [31:0] pc;
        logic        ds;
    } exp_t;

    exp_t        exc_q[$];
    logic [31:0] redir_q[$];

    logic exp_en = 1'b0, exp_flush = 1'b0, exp_redir = 1'b0;
    logic chk_reset = 1'b1, done = 1'b0;
    int   n_checks = 0, n_fails = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("except_en", 32'(except_en_o), 32'(exp_en));
        check("flush", 32'(flush_o), 32'(exp_flush));
        check("redirect", 32'(redirect_o), 32'(exp_redir));
        if (chk_reset) check("reset_redirect_pc", redirect_pc_o, 32'h0);
        if (except_en_o === 1'b1) begin
            if (exc_q.size() == 0) begin
                check("unexpected_exception", 32'(except_en_o), 32'h0);
            end else begin
                exp_t e;
                e = exc_q.pop_front();
                check("except_type", except_type_o, e.typ);
                check("badvaddr", badvaddr_o, e.badv);
                check("except_pc", except_pc_o, e.pc);
                check("delayslot", 32'(except_delayslot_o), 32'(e.ds));
                check("mem_kill", 32'(mem_kill_o), 32'h1);
            end
        end else begin
            check("idle_type", except_type_o, 32'h0);
            check("idle_kill", 32'(mem_kill_o), 32'h0);
        end
        if (redirect_o === 1'b1) begin
            if (redir_q.size() == 0) check("unexpected_redirect", 32'(redirect_o), 32'h0);
            else check("redirect_pc", redirect_pc_o, redir_q.pop_front());
        end
        if (done) begin
            check("exc_queue_drained", 32'(exc_q.size()), 32'h0);
            check("redir_queue_drained", 32'(redir_q.size()), 32'h0);
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
            $finish;
        end
    end

    task automatic cyc(input logic en, input logic fl, input logic rd);
        @(posedge clk);
        #1;
        exp_en    = en;
        exp_flush = fl;
        exp_redir = rd;
    endtask

    task automatic clear_flags();
        inst_valid_i = 1'b1; stall_i = 1'b0;
        if_adel_i = 1'b0; id_ri_i = 1'b0; id_sys_i = 1'b0; id_bp_i = 1'b0;
        id_eret_i = 1'b0; ex_ov_i = 1'b0; mem_adel_i = 1'b0; mem_ades_i = 1'b0;
        cause_i = '0; chk_reset = 1'b0;
    endtask

    task automatic expect_exc(input logic [31:0] typ, input logic [31:0] badv,
                              input logic [31:0] rpc);
        exp_t e;
        e.typ = typ; e.badv = badv; e.pc = pc_i; e.ds = is_in_delayslot_i;
        exc_q.push_back(e);
        redir_q.push_back(rpc);
    endtask

    // Cycles T+1 .. T+FC+1 after a take; optionally offer a SYSCALL in T+1.
    task automatic span(input logic sys_t1);
        cyc(1'b0, 1'b1, 1'b1); clear_flags(); id_sys_i = sys_t1;
        for (int unsigned k = 1; k < FC; k++) begin
            cyc(1'b0, 1'b1, 1'b0); clear_flags();
        end
        cyc(1'b0, 1'b0, 1'b0); clear_flags();
    endtask

    initial begin
        rst = 1'b1; inst_valid_i = 1'b0; stall_i = 1'b0; is_in_delayslot_i = 1'b0;
        pc_i = '0; mem_addr_i = '0; status_i = '0; cause_i = '0; epc_i = '0;
        if_adel_i = 1'b0; id_ri_i = 1'b0; id_sys_i = 1'b0; id_bp_i = 1'b0;
        id_eret_i = 1'b0; ex_ov_i = 1'b0; mem_adel_i = 1'b0; mem_ades_i = 1'b0;
        timer_int_i = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0); rst = 1'b0;

        // Overflow with BEV=1
        cyc(1'b1, 1'b1, 1'b0); clear_flags();
        ex_ov_i = 1'b1; pc_i = 32'hBFC0_0100; status_i = 32'h0040_0000; mem_addr_i = 32'h1111_0000;
        expect_exc(32'd12, 32'h1111_0000, 32'hBFC0_0380);
        span(1'b0);

        // Load misalign in delay slot, BEV=0
        cyc(1'b1, 1'b1, 1'b0); clear_flags();
        mem_adel_i = 1'b1; mem_addr_i = 32'h0000_0003; is_in_delayslot_i = 1'b1;
        pc_i = 32'h8000_0100; status_i = 32'h0;
        expect_exc(32'd4, 32'h0000_0003, 32'h8000_0380);
        span(1'b0); is_in_delayslot_i = 1'b0;

        // Fetch ADEL beats overflow; badvaddr is the PC
        cyc(1'b1, 1'b1, 1'b0); clear_flags();
        if_adel_i = 1'b1; ex_ov_i = 1'b1; pc_i = 32'h8000_0002; mem_addr_i = 32'h1234_5678;
        expect_exc(32'd4, 32'h8000_0002, 32'h8000_0380);
        span(1'b0);

        // Store misalign below overflow priority is not reached here: ADES alone
        cyc(1'b1, 1'b1, 1'b0); clear_flags();
        mem_ades_i = 1'b1; mem_addr_i = 32'h0000_0006; pc_i = 32'h8000_0040; status_i = 32'h0040_0000;
        expect_exc(32'd5, 32'h0000_0006, 32'hBFC0_0380);
        span(1'b0);

        // SYS and BP together: SYS wins; mem_ades lower still
        cyc(1'b1, 1'b1, 1'b0); clear_flags();
        id_sys_i = 1'b1; id_bp_i = 1'b1; mem_ades_i = 1'b1; status_i = 32'h0;
        expect_exc(32'd8, 32'h0000_0006, 32'h8000_0380);
        span(1'b0);

        // Bubble carrying a flag: no take
        cyc(1'b0, 1'b0, 1'b0); clear_flags(); inst_valid_i = 1'b0; ex_ov_i = 1'b1;

        // Interrupt held off by stall, taken when released
        cyc(1'b0, 1'b0, 1'b0); clear_flags();
        stall_i = 1'b1; cause_i = 32'h0000_0100; status_i = 32'h0040_0101; pc_i = 32'h8000_0500;
        cyc(1'b1, 1'b1, 1'b0); stall_i = 1'b0;
        expect_exc(32'd1, mem_addr_i, 32'hBFC0_0380);
        span(1'b0);

        // EXL=1 masks the interrupt
        cyc(1'b0, 1'b0, 1'b0); clear_flags(); cause_i = 32'h0000_0100; status_i = 32'h0040_0103;
        cyc(1'b0, 1'b0, 1'b0); clear_flags();

        // ERET with pending interrupt reports INT
        cyc(1'b1, 1'b1, 1'b0); clear_flags();
        id_eret_i = 1'b1; epc_i = 32'h8000_1234; cause_i = 32'h0000_0100; status_i = 32'h0000_0101;
        expect_exc(32'd1, mem_addr_i, 32'h8000_0380);
        span(1'b0);

        // ERET: redirect to EPC; SYSCALL in T+1 ignored
        cyc(1'b1, 1'b1, 1'b0); clear_flags();
        id_eret_i = 1'b1; status_i = 32'h0; pc_i = 32'h8000_0400; mem_addr_i = 32'h0000_0055;
        expect_exc(32'd14, 32'h0000_0055, 32'h8000_1234);
        span(1'b1);

        // Reset in T+1 cancels flush; new flag at T+3 taken normally
        cyc(1'b1, 1'b1, 1'b0); clear_flags();
        id_bp_i = 1'b1; pc_i = 32'h8000_0200;
        expect_exc(32'd9, 32'h0000_0055, 32'h8000_0380);
        cyc(1'b0, 1'b1, 1'b1); clear_flags(); rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0); clear_flags(); rst = 1'b0; chk_reset = 1'b1;
        cyc(1'b1, 1'b1, 1'b0); clear_flags();
        id_ri_i = 1'b1; pc_i = 32'h8000_0300;
        expect_exc(32'd10, 32'h0000_0055, 32'h8000_0380);
        span(1'b0);

        cyc(1'b0, 1'b0, 1'b0); clear_flags(); done = 1'b1;
        repeat (5) @(posedge clk);
        $display("FAIL timeout: monitor did not finish");
        $fatal(1);
    end

endmodule
